lsu_wb_stage: RTL and testbench
===============================

Name: lsu_wb_stage

Overview:
- Memory/writeback stage of the 3-stage core; consumes the registered execute→memory signals and sits directly downstream of the execute/memory pipeline register.
- Performs loads and stores over a req/ack data bus, formats load data, selects the writeback value and drives the register-file write port.
- Drives stall_o to the hazard logic while a bus transaction is outstanding.

Parameters:
- DW, 32, datapath width; only 32 is supported.
- REGW, 5, register index width.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous active-low reset.
- alu_out_m  in  DW  ALU result; this is the memory address for loads and stores.
- write_data_m  in  DW  store data (rs2).
- rd_m  in  REGW  destination register.
- pc_plus_4_m  in  DW  link value.
- reg_write_m  in  1  register write enable.
- wb_sel_m  in  2  writeback select: 00 ALU, 01 load, 10 PC+4, 11 CSR.
- mem_write_m  in  1  store.
- func3_m  in  3  access size/sign.
- csr_rdata_m  in  DW  CSR read value.
- dbus_req_o  out  1  bus request.
- dbus_we_o  out  1  bus write.
- dbus_addr_o  out  DW  word-aligned bus address.
- dbus_wdata_o  out  DW  lane-replicated store data.
- dbus_be_o  out  4  byte enables.
- dbus_ack_i  in  1  bus acknowledge.
- dbus_rdata_i  in  DW  bus read data, valid with ack.
- stall_o  out  1  freeze fetch and the pipeline registers.
- rf_we_o  out  1  register-file write enable.
- rf_waddr_o  out  REGW  write address.
- rf_wdata_o  out  DW  write data.
- misalign_o  out  1  misaligned access flag (feature only; tied 0 otherwise).

Behaviour:
- Clock and reset: one clock, clk_i. Reset rst_ni is asynchronous, active-low.
- Reset values: state IDLE, dbus_req_o 0, dbus_we_o 0, dbus_addr_o 0, dbus_wdata_o 0, dbus_be_o 0, the load-data register 0, misalign_o 0. stall_o and rf_we_o are 0 while rst_ni is low.
- mem_op = mem_write_m | (wb_sel_m == 01).
- FSM states: IDLE, REQ, DONE.
- IDLE:
  - If mem_op: register address, data, byte enables and we; go to REQ; stall_o = 1.
  - Else: stall_o = 0.
  - dbus_ack_i is ignored in IDLE.
- REQ:
  - dbus_req_o = 1 and request fields are held stable until the ack cycle.
  - On dbus_ack_i: dbus_req_o drops next cycle, the formatted load data is registered, go to DONE.
  - stall_o = 1 throughout REQ.
- DONE: stall_o = 0; a load writes back here; return to IDLE. The same instruction is therefore never re-issued.
- Minimum memory-op occupancy: 3 cycles, with ack arriving in the first REQ cycle. Each extra wait cycle adds one.
- Address: dbus_addr_o = {alu_out_m[31:2], 2'b00}. Byte lane = alu_out_m[1:0].
- Stores:
  - sb (000): be = 0001 << a[1:0]; wdata = 4 copies of the byte.
  - sh (001): be = 0011 << {a[1],0}; wdata = 2 copies of the halfword.
  - sw (010): be = 1111.
  - Other func3 values: be = 0000, but the transaction still completes.
- Loads:
  - be = 1111 for every load.
  - The selected lane is shifted down and then extended.
  - lb (000) and lh (001) sign-extend.
  - lw (010) passes the word through.
  - lbu (100) and lhu (101) zero-extend.
  - Other func3 values return 0.
- Writeback:
  - rf_waddr_o = rd_m.
  - rf_wdata_o muxed by wb_sel_m: 00 alu_out_m, 01 load register, 10 pc_plus_4_m, 11 csr_rdata_m.
  - For non-load ops, rf_we_o = reg_write_m & (rd_m != 0), combinational in the same cycle.
  - Loads assert rf_we_o only in DONE. Stores never write.
- Reset mid-transaction: immediately returns to IDLE, request dropped. A later ack for the abandoned request is ignored.

Optional Feature:
- Macro: LSU_MISALIGN_TRAP_EN.
- Enabled:
  - Misaligned cases are lh/lhu/sh with a[0] = 1, and lw/sw with a[1:0] != 0.
  - On a misaligned case, misalign_o pulses for 1 cycle in IDLE; no bus request is made; the FSM goes straight to DONE with rf_we_o = 0 and the store suppressed.
- Disabled:
  - misalign_o is tied 0.
  - Low address bits beyond access alignment are ignored: halfword uses a[1] only, word uses neither.

Test Plan:
- sw x5=0xDEADBEEF to 0x100, ack in 1st REQ cycle → req 1 cycle, addr 0x100, be 1111, wdata 0xDEADBEEF, stall_o high 2 cycles, rf_we_o 0 throughout.
- lb from 0x203 with rdata 0x80FF1234, ack after 3 wait cycles → be 1111; DONE writes 0xFFFFFF80 to rd; stall_o high 5 cycles. lbu from 0x203 → 0x00000080.
- sh 0xABCD to 0x002 → be 1100, wdata 0xABCDABCD. sb 0x7E to 0x001 → be 0010, wdata 0x7E7E7E7E.
- ALU op rd = 0 with reg_write_m = 1 → rf_we_o 0. rd = 3, wb_sel 10, pc_plus_4 0x44 → rf_we_o 1 and rf_wdata_o 0x44 in the same cycle, stall_o 0.
- Load in REQ, rst_ni low for 1 cycle, then ack arrives → FSM IDLE, dbus_req_o 0, no writeback, stall_o 0.
- With LSU_MISALIGN_TRAP_EN: lw at 0x102 → misalign_o 1 cycle, no dbus_req_o, rf_we_o 0. Without it: addr 0x100, normal load.

Source files
------------

// File: rtl/lsu_wb_stage.sv
// lsu_wb_stage: memory/writeback stage of the 3-stage core.
// Runs loads and stores over a req/ack data bus, formats load data,
// selects the writeback value and drives the register-file write port.
// stall_o holds the upstream pipeline while a bus access is in flight.
// Optional feature macro: LSU_MISALIGN_TRAP_EN (misaligned access detection).
module lsu_wb_stage #(
  parameter int unsigned DW   = 32,
  parameter int unsigned REGW = 5
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic [DW-1:0]   alu_out_m,
  input  logic [DW-1:0]   write_data_m,
  input  logic [REGW-1:0] rd_m,
  input  logic [DW-1:0]   pc_plus_4_m,
  input  logic            reg_write_m,
  input  logic [1:0]      wb_sel_m,
  input  logic            mem_write_m,
  input  logic [2:0]      func3_m,
  input  logic [DW-1:0]   csr_rdata_m,
  output logic            dbus_req_o,
  output logic            dbus_we_o,
  output logic [DW-1:0]   dbus_addr_o,
  output logic [DW-1:0]   dbus_wdata_o,
  output logic [3:0]      dbus_be_o,
  input  logic            dbus_ack_i,
  input  logic [DW-1:0]   dbus_rdata_i,
  output logic            stall_o,
  output logic            rf_we_o,
  output logic [REGW-1:0] rf_waddr_o,
  output logic [DW-1:0]   rf_wdata_o,
  output logic            misalign_o
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_DONE} state_t;

  state_t          r_state;
  logic            r_req;
  logic            r_we;
  logic [DW-1:0]   r_addr;
  logic [DW-1:0]   r_wdata;
  logic [3:0]      r_be;
  logic [DW-1:0]   r_ldata;
  logic            r_trap;

  logic            w_is_load;
  logic            w_mem_op;
  logic            w_misalign;
  logic            w_wb_ok;
  logic [3:0]      w_st_be;
  logic [DW-1:0]   w_st_wdata;
  logic [7:0]      w_byte;
  logic [15:0]     w_half;
  logic [DW-1:0]   w_ldata;

  assign w_is_load = ~mem_write_m & (wb_sel_m == 2'b01);
  assign w_mem_op  = mem_write_m | (wb_sel_m == 2'b01);
  assign w_wb_ok   = reg_write_m & (rd_m != '0);

  // Store byte enables and lane-replicated store data
  always_comb begin
    w_st_be    = 4'b0000;
    w_st_wdata = write_data_m;
    case (func3_m)
      3'b000: begin
        w_st_be    = 4'(4'b0001 << alu_out_m[1:0]);
        w_st_wdata = {4{write_data_m[7:0]}};
      end
      3'b001: begin
        w_st_be    = alu_out_m[1] ? 4'b1100 : 4'b0011;
        w_st_wdata = {2{write_data_m[15:0]}};
      end
      3'b010:  w_st_be = 4'b1111;
      default: w_st_be = 4'b0000;
    endcase
  end

  // Load lane selection and sign/zero extension
  always_comb begin
    case (alu_out_m[1:0])
      2'd0:    w_byte = dbus_rdata_i[7:0];
      2'd1:    w_byte = dbus_rdata_i[15:8];
      2'd2:    w_byte = dbus_rdata_i[23:16];
      default: w_byte = dbus_rdata_i[31:24];
    endcase
    w_half = alu_out_m[1] ? dbus_rdata_i[31:16] : dbus_rdata_i[15:0];
    case (func3_m)
      3'b000:  w_ldata = {{24{w_byte[7]}}, w_byte};
      3'b001:  w_ldata = {{16{w_half[15]}}, w_half};
      3'b010:  w_ldata = dbus_rdata_i;
      3'b100:  w_ldata = {24'd0, w_byte};
      3'b101:  w_ldata = {16'd0, w_half};
      default: w_ldata = '0;
    endcase
  end

`ifdef LSU_MISALIGN_TRAP_EN
  // Halfword accesses need a[0]=0, word accesses need a[1:0]=0
  always_comb begin
    w_misalign = 1'b0;
    if (w_mem_op) begin
      if ((func3_m == 3'b001) || (w_is_load && (func3_m == 3'b101)))
        w_misalign = alu_out_m[0];
      else if (func3_m == 3'b010)
        w_misalign = |alu_out_m[1:0];
    end
  end
  assign misalign_o = rst_ni & (r_state == S_IDLE) & w_misalign;
`else
  assign w_misalign = 1'b0;
  assign misalign_o = 1'b0;
`endif

  // Bus transaction FSM with registered request fields and load data
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= S_IDLE;
      r_req   <= 1'b0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_be    <= 4'b0000;
      r_ldata <= '0;
      r_trap  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_trap <= 1'b0;
          if (w_mem_op) begin
            if (w_misalign) begin
              r_trap  <= 1'b1;
              r_state <= S_DONE;
            end else begin
              r_req   <= 1'b1;
              r_we    <= mem_write_m;
              r_addr  <= {alu_out_m[DW-1:2], 2'b00};
              r_wdata <= w_st_wdata;
              r_be    <= mem_write_m ? w_st_be : 4'b1111;
              r_state <= S_REQ;
            end
          end
        end
        S_REQ: begin
          if (dbus_ack_i) begin
            r_req   <= 1'b0;
            r_we    <= 1'b0;
            r_ldata <= w_ldata;
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          r_trap  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Writeback value select
  always_comb begin
    case (wb_sel_m)
      2'b00:   rf_wdata_o = alu_out_m;
      2'b01:   rf_wdata_o = r_ldata;
      2'b10:   rf_wdata_o = pc_plus_4_m;
      default: rf_wdata_o = csr_rdata_m;
    endcase
  end

  assign stall_o = rst_ni & (((r_state == S_IDLE) & w_mem_op) | (r_state == S_REQ));
  assign rf_we_o = rst_ni & w_wb_ok &
                   (((r_state == S_IDLE) & ~w_mem_op) |
                    ((r_state == S_DONE) & w_is_load & ~r_trap));
  assign rf_waddr_o   = rd_m;
  assign dbus_req_o   = r_req;
  assign dbus_we_o    = r_we;
  assign dbus_addr_o  = r_addr;
  assign dbus_wdata_o = r_wdata;
  assign dbus_be_o    = r_be;

endmodule

// File: tb/tb_lsu_wb_stage.sv
// Directed bench for lsu_wb_stage: stores, loads, ALU writeback, reset abort,
// and misaligned word load (behaviour depends on LSU_MISALIGN_TRAP_EN).
module tb_lsu_wb_stage;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic [31:0] alu_out_m, write_data_m, pc_plus_4_m, csr_rdata_m;
  logic [4:0]  rd_m;
  logic        reg_write_m, mem_write_m;
  logic [1:0]  wb_sel_m;
  logic [2:0]  func3_m;
  logic        dbus_req_o, dbus_we_o, dbus_ack_i;
  logic [31:0] dbus_addr_o, dbus_wdata_o, dbus_rdata_i;
  logic [3:0]  dbus_be_o;
  logic        stall_o, rf_we_o, misalign_o;
  logic [4:0]  rf_waddr_o;
  logic [31:0] rf_wdata_o;

  int n_chk  = 0;
  int n_pass = 0;

  lsu_wb_stage dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .alu_out_m(alu_out_m), .write_data_m(write_data_m), .rd_m(rd_m),
    .pc_plus_4_m(pc_plus_4_m), .reg_write_m(reg_write_m), .wb_sel_m(wb_sel_m),
    .mem_write_m(mem_write_m), .func3_m(func3_m), .csr_rdata_m(csr_rdata_m),
    .dbus_req_o(dbus_req_o), .dbus_we_o(dbus_we_o), .dbus_addr_o(dbus_addr_o),
    .dbus_wdata_o(dbus_wdata_o), .dbus_be_o(dbus_be_o), .dbus_ack_i(dbus_ack_i),
    .dbus_rdata_i(dbus_rdata_i), .stall_o(stall_o), .rf_we_o(rf_we_o),
    .rf_waddr_o(rf_waddr_o), .rf_wdata_o(rf_wdata_o), .misalign_o(misalign_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  task automatic drive(input logic mw, input logic [1:0] wbs, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] wd,
                       input logic [4:0] rd, input logic rw);
    mem_write_m = mw; wb_sel_m = wbs; func3_m = f3; alu_out_m = a;
    write_data_m = wd; rd_m = rd; reg_write_m = rw;
  endtask

  // Runs one memory op from its IDLE cycle through DONE; ack after 'waits' wait cycles
  task automatic mem_txn(input int waits, output int stall_cyc, output int req_cyc,
                         output logic [31:0] addr, output logic [31:0] wdata,
                         output logic [3:0] be, output logic we, output logic early_we,
                         output logic done_we, output logic [31:0] done_data,
                         output logic done);
    stall_cyc = 0; req_cyc = 0; addr = '0; wdata = '0; be = '0; we = 1'b0;
    early_we = 1'b0; done_we = 1'b0; done_data = '0; done = 1'b0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk_i);
      dbus_ack_i = 1'b0;
      if (stall_o) stall_cyc++;
      if (dbus_req_o) begin
        req_cyc++;
        addr = dbus_addr_o; wdata = dbus_wdata_o; be = dbus_be_o; we = dbus_we_o;
        if (req_cyc == waits + 1) dbus_ack_i = 1'b1;
        if (rf_we_o) early_we = 1'b1;
      end else if (req_cyc > 0 && !stall_o) begin
        done_we = rf_we_o; done_data = rf_wdata_o; done = 1'b1;
        break;
      end else if (rf_we_o) early_we = 1'b1;
    end
  endtask

  task automatic next_idle();
    @(posedge clk_i); #1;
    drive(1'b0, 2'b00, 3'b000, 32'h0, 32'h0, 5'd0, 1'b0);
    @(posedge clk_i); #1;
  endtask

  int          sc, rc;
  logic [31:0] ad, wdt, dd;
  logic [3:0]  bev;
  logic        wev, ewe, dwe, dn;

  initial begin
    rst_ni = 1'b0; dbus_ack_i = 1'b0; dbus_rdata_i = '0;
    pc_plus_4_m = '0; csr_rdata_m = '0;
    drive(1'b0, 2'b00, 3'b000, 32'h0, 32'h0, 5'd0, 1'b0);
    repeat (2) @(negedge clk_i);
    chk("rst_req", 32'(dbus_req_o), 32'd0);
    chk("rst_stall", 32'(stall_o), 32'd0);
    chk("rst_addr", dbus_addr_o, 32'h0);
    chk("rst_be", 32'(dbus_be_o), 32'h0);
    chk("rst_misalign", 32'(misalign_o), 32'd0);
    rst_ni = 1'b1;
    @(posedge clk_i); #1;

    // sw 0xDEADBEEF to 0x100, immediate ack
    drive(1'b1, 2'b00, 3'b010, 32'h100, 32'hDEADBEEF, 5'd7, 1'b1);
    mem_txn(0, sc, rc, ad, wdt, bev, wev, ewe, dwe, dd, dn);
    chk("sw_done", 32'(dn), 32'd1);
    chk("sw_stall", 32'(sc), 32'd2);
    chk("sw_req", 32'(rc), 32'd1);
    chk("sw_addr", ad, 32'h100);
    chk("sw_be", 32'(bev), 32'hF);
    chk("sw_wdata", wdt, 32'hDEADBEEF);
    chk("sw_we", 32'(wev), 32'd1);
    chk("sw_rfwe", 32'(ewe | dwe), 32'd0);
    next_idle();

    // lb from 0x203, three wait cycles
    dbus_rdata_i = 32'h80FF1234;
    drive(1'b0, 2'b01, 3'b000, 32'h203, 32'h0, 5'd9, 1'b1);
    mem_txn(3, sc, rc, ad, wdt, bev, wev, ewe, dwe, dd, dn);
    chk("lb_done", 32'(dn), 32'd1);
    chk("lb_stall", 32'(sc), 32'd5);
    chk("lb_req", 32'(rc), 32'd4);
    chk("lb_addr", ad, 32'h200);
    chk("lb_be", 32'(bev), 32'hF);
    chk("lb_we", 32'(wev), 32'd0);
    chk("lb_early_we", 32'(ewe), 32'd0);
    chk("lb_rfwe", 32'(dwe), 32'd1);
    chk("lb_data", dd, 32'hFFFFFF80);
    next_idle();

    // lbu / lh / lhu / lw / unsupported load func3
    drive(1'b0, 2'b01, 3'b100, 32'h203, 32'h0, 5'd9, 1'b1);
    mem_txn(0, sc, rc, ad, wdt, bev, wev, ewe, dwe, dd, dn);
    chk("lbu_data", dd, 32'h00000080);
    chk("lbu_stall", 32'(sc), 32'd2);
    next_idle();
    drive(1'b0, 2'b01, 3'b001, 32'h202, 32'h0, 5'd9, 1'b1);
    mem_txn(1, sc, rc, ad, wdt, bev, wev, ewe, dwe, dd, dn);
    chk("lh_data", dd, 32'hFFFF80FF);
    next_idle();
    drive(1'b0, 2'b01, 3'b101, 32'h202, 32'h0, 5'd9, 1'b1);
    mem_txn(0, sc, rc, ad, wdt, bev, wev, ewe, dwe, dd, dn);
    chk("lhu_data", dd, 32'h000080FF);
    next_idle();
    drive(1'b0, 2'b01, 3'b010, 32'h100, 32'h0, 5'd9, 1'b1);
    mem_txn(0, sc, rc, ad, wdt, bev, wev, ewe, dwe, dd, dn);
    chk("lw_data", dd, 32'h80FF1234);
    next_idle();
    drive(1'b0, 2'b01, 3'b011, 32'h100, 32'h0, 5'd9, 1'b1);
    mem_txn(0, sc, rc, ad, wdt, bev, wev, ewe, dwe, dd, dn);
    chk("lbad_data", dd, 32'h0);
    next_idle();

    // sh / sb / unsupported store func3
    drive(1'b1, 2'b00, 3'b001, 32'h002, 32'h1234ABCD, 5'd0, 1'b0);
    mem_txn(0, sc, rc, ad, wdt, bev, wev, ewe, dwe, dd, dn);
    chk("sh_be", 32'(bev), 32'hC);
    chk("sh_wdata", wdt, 32'hABCDABCD);
    chk("sh_addr", ad, 32'h0);
    next_idle();
    drive(1'b1, 2'b00, 3'b000, 32'h001, 32'h0000007E, 5'd0, 1'b0);
    mem_txn(0, sc, rc, ad, wdt, bev, wev, ewe, dwe, dd, dn);
    chk("sb_be", 32'(bev), 32'h2);
    chk("sb_wdata", wdt, 32'h7E7E7E7E);
    next_idle();
    drive(1'b1, 2'b00, 3'b011, 32'h010, 32'h11111111, 5'd0, 1'b0);
    mem_txn(2, sc, rc, ad, wdt, bev, wev, ewe, dwe, dd, dn);
    chk("sbad_be", 32'(bev), 32'h0);
    chk("sbad_done", 32'(dn), 32'd1);
    next_idle();

    // ALU-class writebacks
    drive(1'b0, 2'b00, 3'b000, 32'h55, 32'h0, 5'd0, 1'b1);
    @(negedge clk_i);
    chk("x0_rfwe", 32'(rf_we_o), 32'd0);
    chk("x0_stall", 32'(stall_o), 32'd0);
    pc_plus_4_m = 32'h44;
    drive(1'b0, 2'b10, 3'b000, 32'h55, 32'h0, 5'd3, 1'b1);
    #1;
    chk("link_rfwe", 32'(rf_we_o), 32'd1);
    chk("link_data", rf_wdata_o, 32'h44);
    chk("link_addr", 32'(rf_waddr_o), 32'd3);
    chk("link_stall", 32'(stall_o), 32'd0);
    drive(1'b0, 2'b00, 3'b000, 32'h1234, 32'h0, 5'd4, 1'b1);
    #1;
    chk("alu_data", rf_wdata_o, 32'h1234);
    csr_rdata_m = 32'hC5C5_0001;
    drive(1'b0, 2'b11, 3'b000, 32'h1234, 32'h0, 5'd4, 1'b1);
    #1;
    chk("csr_data", rf_wdata_o, 32'hC5C50001);
    drive(1'b0, 2'b00, 3'b000, 32'h1234, 32'h0, 5'd4, 1'b0);
    #1;
    chk("nowr_rfwe", 32'(rf_we_o), 32'd0);
    next_idle();

    // reset while a load is waiting on the bus; the late ack must be ignored
    drive(1'b0, 2'b01, 3'b010, 32'h300, 32'h0, 5'd6, 1'b1);
    @(negedge clk_i);
    @(negedge clk_i);
    chk("ab_req_before", 32'(dbus_req_o), 32'd1);
    rst_ni = 1'b0;
    drive(1'b0, 2'b00, 3'b000, 32'h0, 32'h0, 5'd0, 1'b0);
    #1;
    chk("ab_req_rst", 32'(dbus_req_o), 32'd0);
    chk("ab_stall_rst", 32'(stall_o), 32'd0);
    @(negedge clk_i);
    rst_ni = 1'b1; dbus_ack_i = 1'b1;
    @(negedge clk_i);
    chk("ab_req_ack", 32'(dbus_req_o), 32'd0);
    chk("ab_stall_ack", 32'(stall_o), 32'd0);
    chk("ab_rfwe_ack", 32'(rf_we_o), 32'd0);
    dbus_ack_i = 1'b0;
    @(negedge clk_i);
    chk("ab_req_later", 32'(dbus_req_o), 32'd0);
    @(posedge clk_i); #1;

    // lw at 0x102
    dbus_rdata_i = 32'hCAFEF00D;
    drive(1'b0, 2'b01, 3'b010, 32'h102, 32'h0, 5'd8, 1'b1);
`ifdef LSU_MISALIGN_TRAP_EN
    @(negedge clk_i);
    chk("mis_pulse", 32'(misalign_o), 32'd1);
    chk("mis_req0", 32'(dbus_req_o), 32'd0);
    @(negedge clk_i);
    chk("mis_pulse_end", 32'(misalign_o), 32'd0);
    chk("mis_req1", 32'(dbus_req_o), 32'd0);
    chk("mis_rfwe", 32'(rf_we_o), 32'd0);
    chk("mis_stall", 32'(stall_o), 32'd0);
`else
    mem_txn(0, sc, rc, ad, wdt, bev, wev, ewe, dwe, dd, dn);
    chk("mis_addr", ad, 32'h100);
    chk("mis_data", dd, 32'hCAFEF00D);
    chk("mis_flag", 32'(misalign_o), 32'd0);
`endif
    next_idle();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
